psec5_readout_sequencer: RTL
============================

// Module: psec5_readout_sequencer
// PURPOSE
// - Sequences NCH PSEC5_CH_DIGITAL channels through one acquisition: arm, wait for trigger, stop, and serial readout.
// - Arms all enabled channels with INST_START and waits for any STOP_REQUEST, then broadcasts INST_STOP.
// - Then, per enabled channel in ascending index order: strobes INST_READOUT, loads bytes 0..6 via LOAD_CNT_SER/SELECT_REG, and shifts each byte in over SPI_CLK.
// - Delivers bytes on a valid/ready stream to the chip-level SPI/FIFO block.
// PARAMETERS
// - NCH         8    number of channels, 1..16
// - SCLK_HALF   2    FCLK cycles per SPI_CLK phase (high or low), >=1
// - START_W     4    INST_START pulse width, FCLK cycles
// - TRIG_TO     0    WAIT_TRIG timeout in FCLK cycles; 0 = no timeout
// PORTS
// - FCLK          in   1      clock
// - RSTB          in   1      asynchronous reset, active-low
// - cmd_start     in   1      1-cycle request to begin an acquisition
// - cmd_abort     in   1      1-cycle request to return to IDLE
// - chan_mask     in   NCH    enabled channels; sampled at cmd_start
// - auto_rearm    in   1      re-arm after readout instead of going to IDLE
// - stop_req      in   NCH    per-channel STOP_REQUEST (already synchronised)
// - cnt_ser       in   NCH    per-channel CNT_SER
// - inst_start    out  NCH    INST_START, masked per channel
// - inst_stop     out  NCH    INST_STOP, broadcast to enabled channels
// - inst_readout  out  NCH    INST_READOUT, one-hot to the current channel
// - load_cnt_ser  out  NCH    LOAD_CNT_SER, one-hot to the current channel
// - select_reg    out  3      byte index 0..6
// - spi_clk       out  NCH    shift clock, one-hot gated to the current channel
// - out_data      out  8      assembled byte
// - out_chan      out  4      channel index of out_data
// - out_last      out  1      last byte of the acquisition
// - out_valid     out  1      out_data valid
// - out_ready     in   1      sink accepts when out_valid & out_ready
// - busy          out  1      state != IDLE
// - timed_out     out  1      sticky; cleared at cmd_start
// - err_mask      out  1      1-cycle pulse: cmd_start received with chan_mask==0
// BEHAVIOUR
// - Reset values: all outputs 0, state IDLE, counters 0. Reset mid-operation drops every strobe in the same cycle.
// - All outputs are registered and glitch-free.
// - States: IDLE -> ARM -> WAIT_TRIG -> STOP -> RDSTB -> LOAD -> SHIFT -> PUSH -> (LOAD | RDSTB | ARM | IDLE).
// - IDLE: on cmd_start with mask!=0, latch the mask and go to ARM. With mask==0, pulse err_mask and stay in IDLE. cmd_start outside IDLE is ignored.
// - ARM: inst_start = latched mask for START_W cycles, then WAIT_TRIG.
// - WAIT_TRIG: leave when |(stop_req & mask) or when TRIG_TO expires (set timed_out). Trigger and timeout in the same cycle count as a trigger; timed_out stays 0.
// - STOP: inst_stop = mask for 2 cycles. Select the lowest enabled channel ch and set byte index b=0.
// - RDSTB: inst_readout[ch] high for 2 cycles.
// - LOAD: select_reg=b is set 1 cycle before, and held during, a 2-cycle load_cnt_ser[ch] pulse. select_reg holds until the next LOAD.
// - SHIFT: 8 spi_clk periods of 2*SCLK_HALF cycles each, starting low. Sample cnt_ser[ch] on the last FCLK of each high phase. Bit k goes to out_data[k] (LSB first). spi_clk ends low.
// - PUSH: out_valid=1 with out_chan=ch and out_last=(last enabled ch && b==6); data is stable until accepted.
// - After PUSH accept: b<6 -> b+1, LOAD; b==6 -> next enabled ch, RDSTB.
// - After the last channel: auto_rearm ? ARM : IDLE.
// - Backpressure: out_ready low holds PUSH indefinitely with spi_clk low and no strobes.
// - cmd_abort in any state: the next state is IDLE, all strobes drop, out_valid drops, and a partial byte is discarded. Abort wins over a simultaneous accept.
// - Multiple stop_req bits set: all enabled channels are still read, in ascending order.
// - Per enabled channel, latency from the STOP exit is deterministic: 2 + 7*(3 + 16*SCLK_HALF + push) FCLK cycles.
// CONFIGURATION
// - PSEC5_RD_HEADER_EN defined: before byte 0 of each channel, emit a header byte {4'hA, ch[3:0]} in PUSH (out_last=0), then continue to LOAD. Each channel yields 8 bytes.
// - PSEC5_RD_HEADER_EN undefined: no header; each channel yields 7 bytes.
// TESTING
// - Mask 8'h05, stop_req[2] rises -> inst_start=8'h05 for 4 cycles, inst_stop=8'h05, then 14 bytes: ch0 b0..6, then ch2 b0..6. out_last only on ch2 b6.
// - Channel model loaded with CA=10'h3A5 -> ch0 byte0=8'hA5, byte1[1:0]=2'b11. Bits arrive LSB first and match the model's cbuffer.
// - TRIG_TO=100, no trigger -> after 100 cycles timed_out=1 and the readout runs; at the next cmd_start timed_out=0.
// - out_ready held low 50 cycles during PUSH -> out_data stable, spi_clk=0, no load/readout pulses; resumes on ready.
// - cmd_abort during SHIFT bit 3 -> next cycle IDLE, busy=0, all strobes 0, no out_valid; cmd_start with mask 0 -> err_mask pulse, busy stays 0.
// - RSTB low mid-SHIFT -> all outputs 0 asynchronously. With PSEC5_RD_HEADER_EN and mask 8'h02: first byte 8'hA1, total 8 bytes.

Source files
------------

// File: rtl/psec5_readout_sequencer.sv
// psec5_readout_sequencer: arms PSEC5 channels, waits for a trigger, then reads each enabled channel's bytes out serially.
// Optional feature macro: PSEC5_RD_HEADER_EN prefixes each channel's bytes with a {4'hA, ch} header byte.
module psec5_readout_sequencer #(
    parameter int unsigned NCH       = 8,
    parameter int unsigned SCLK_HALF = 2,
    parameter int unsigned START_W   = 4,
    parameter int unsigned TRIG_TO   = 0
) (
    input  logic           FCLK,
    input  logic           RSTB,
    input  logic           cmd_start,
    input  logic           cmd_abort,
    input  logic [NCH-1:0] chan_mask,
    input  logic           auto_rearm,
    input  logic [NCH-1:0] stop_req,
    input  logic [NCH-1:0] cnt_ser,
    output logic [NCH-1:0] inst_start,
    output logic [NCH-1:0] inst_stop,
    output logic [NCH-1:0] inst_readout,
    output logic [NCH-1:0] load_cnt_ser,
    output logic [2:0]     select_reg,
    output logic [NCH-1:0] spi_clk,
    output logic [7:0]     out_data,
    output logic [3:0]     out_chan,
    output logic           out_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy,
    output logic           timed_out,
    output logic           err_mask
);
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned CH_W    = 4;
    localparam int unsigned PH_W    = $clog2(2*SCLK_HALF + 1);
    localparam int unsigned PH_LAST = 2*SCLK_HALF - 1;

    typedef enum logic [2:0] {IDLE, ARM, WAIT_TRIG, STOP, RDSTB, LOAD, SHIFT, PUSH} state_t;

    state_t           state_q, state_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic [NCH-1:0]   mask_q, mask_nx;
    logic [CH_W-1:0]  ch_q, ch_nx, first_ch, next_ch;
    logic             more;
    logic [2:0]       b_q, b_nx, bit_q, bit_nx;
    logic [PH_W-1:0]  ph_q, ph_nx;
    logic [7:0]       sr_q, sr_nx;
    logic             hdr_q, hdr_nx;
    logic             tmo_nx, err_nx;
    logic [NCH-1:0]   oh_q, oh_nx;
    logic [NCH-1:0]   inst_start_nx, inst_stop_nx, inst_readout_nx, load_nx, spi_nx;
    logic [2:0]       sel_nx;
    logic [7:0]       data_nx;
    logic [3:0]       chan_nx;
    logic             last_nx, valid_nx, busy_nx;

    // Lowest enabled channel, and the next enabled channel above the current one.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        more     = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_ch = CH_W'(i);
                if (CH_W'(i) > ch_q) begin
                    next_ch = CH_W'(i);
                    more    = 1'b1;
                end
            end
        end
    end

    // Next state, sequencing counters, and next values of every registered output.
    always_comb begin
        state_nx = state_q;
        mask_nx  = mask_q;
        ch_nx    = ch_q;
        b_nx     = b_q;
        bit_nx   = bit_q;
        ph_nx    = ph_q;
        sr_nx    = sr_q;
        hdr_nx   = hdr_q;
        tmo_nx   = timed_out;
        err_nx   = 1'b0;
        oh_q     = NCH'(1) << ch_q;

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    if (chan_mask != '0) begin
                        mask_nx  = chan_mask;
                        tmo_nx   = 1'b0;
                        state_nx = ARM;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            ARM: if (cnt_q == CNT_W'(START_W - 1)) state_nx = WAIT_TRIG;
            WAIT_TRIG: begin
                if ((stop_req & mask_q) != '0) begin
                    state_nx = STOP;
                end else if (TRIG_TO != 0 && cnt_q == CNT_W'(TRIG_TO - 1)) begin
                    tmo_nx   = 1'b1;
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (cnt_q == CNT_W'(1)) begin
                    ch_nx    = first_ch;
                    b_nx     = '0;
                    state_nx = RDSTB;
                end
            end
            RDSTB: begin
                if (cnt_q == CNT_W'(1)) begin
`ifdef PSEC5_RD_HEADER_EN
                    hdr_nx   = 1'b1;
                    state_nx = PUSH;
`else
                    state_nx = LOAD;
`endif
                end
            end
            LOAD: begin
                if (cnt_q == CNT_W'(2)) begin
                    ph_nx    = '0;
                    bit_nx   = '0;
                    sr_nx    = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                ph_nx = ph_q + PH_W'(1);
                // Last FCLK of the high phase: capture the bit, LSB arrives first.
                if (ph_q == PH_W'(PH_LAST)) begin
                    ph_nx  = '0;
                    sr_nx  = {|(cnt_ser & oh_q), sr_q[7:1]};
                    bit_nx = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_nx = PUSH;
                end
            end
            PUSH: begin
                if (out_ready) begin
                    if (hdr_q) begin
                        hdr_nx   = 1'b0;
                        state_nx = LOAD;
                    end else if (b_q != 3'd6) begin
                        b_nx     = b_q + 3'd1;
                        state_nx = LOAD;
                    end else if (more) begin
                        ch_nx    = next_ch;
                        b_nx     = '0;
                        state_nx = RDSTB;
                    end else begin
                        state_nx = auto_rearm ? ARM : IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        if (cmd_abort) begin
            state_nx = IDLE;
            hdr_nx   = 1'b0;
        end

        cnt_nx = (state_nx != state_q) ? '0 : cnt_q + CNT_W'(1);

        oh_nx           = NCH'(1) << ch_nx;
        inst_start_nx   = (state_nx == ARM)   ? mask_nx : '0;
        inst_stop_nx    = (state_nx == STOP)  ? mask_nx : '0;
        inst_readout_nx = (state_nx == RDSTB) ? oh_nx   : '0;
        load_nx         = (state_nx == LOAD && cnt_nx != '0) ? oh_nx : '0;
        spi_nx          = (state_nx == SHIFT && ph_nx >= PH_W'(SCLK_HALF)) ? oh_nx : '0;
        sel_nx          = (state_nx == LOAD) ? b_nx : select_reg;
        valid_nx        = (state_nx == PUSH);
        data_nx         = out_data;
        chan_nx         = out_chan;
        last_nx         = 1'b0;
        if (state_nx == PUSH) begin
            data_nx = hdr_nx ? {4'hA, ch_nx} : sr_nx;
            chan_nx = ch_nx;
            last_nx = !hdr_nx && (b_nx == 3'd6) && !more;
        end
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge FCLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mask_q       <= '0;
            ch_q         <= '0;
            b_q          <= '0;
            bit_q        <= '0;
            ph_q         <= '0;
            sr_q         <= '0;
            hdr_q        <= 1'b0;
            inst_start   <= '0;
            inst_stop    <= '0;
            inst_readout <= '0;
            load_cnt_ser <= '0;
            select_reg   <= '0;
            spi_clk      <= '0;
            out_data     <= '0;
            out_chan     <= '0;
            out_last     <= 1'b0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            timed_out    <= 1'b0;
            err_mask     <= 1'b0;
        end else begin
            state_q      <= state_nx;
            cnt_q        <= cnt_nx;
            mask_q       <= mask_nx;
            ch_q         <= ch_nx;
            b_q          <= b_nx;
            bit_q        <= bit_nx;
            ph_q         <= ph_nx;
            sr_q         <= sr_nx;
            hdr_q        <= hdr_nx;
            inst_start   <= inst_start_nx;
            inst_stop    <= inst_stop_nx;
            inst_readout <= inst_readout_nx;
            load_cnt_ser <= load_nx;
            select_reg   <= sel_nx;
            spi_clk      <= spi_nx;
            out_data     <= data_nx;
            out_chan     <= chan_nx;
            out_last     <= last_nx;
            out_valid    <= valid_nx;
            busy         <= busy_nx;
            timed_out    <= tmo_nx;
            err_mask     <= err_nx;
        end
    end
endmodule
